xm_tx_frame_arb: RTL and testbench

//  Frame-level arbiter sharing one teng_mac TX lane (AXIS: 32b data, 2b vldb, last, user) among NUM_SRC requesters.

---
 rtl/xm_tx_frame_arb.sv | 214 +++++++++++++++++++++
 tb/tb_xm_tx_frame_arb.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xm_tx_frame_arb.sv
// xm_tx_frame_arb: whole-frame round-robin arbiter onto one teng_mac TX lane.
// Define XM_TX_ARB_PRIO_EN to give source 0 strict priority over the rest.
module xm_tx_frame_arb #(
  parameter int NUM_SRC    = 4,
  parameter int ID_FIFO_AW = 3
) (
  input  logic                   tx_user_clk_i,
  input  logic                   tx_user_rst_n_i,
  input  logic                   link_up_i,
  input  logic [NUM_SRC*32-1:0]  s_tx_data_i,
  input  logic [NUM_SRC*2-1:0]   s_tx_vldb_i,
  input  logic [NUM_SRC-1:0]     s_tx_valid_i,
  output logic [NUM_SRC-1:0]     s_tx_ready_o,
  input  logic [NUM_SRC-1:0]     s_tx_last_i,
  input  logic [NUM_SRC-1:0]     s_tx_user_i,
  output logic [NUM_SRC-1:0]     s_tx_status_o,
  output logic [NUM_SRC-1:0]     s_tx_rsp_valid_o,
  output logic [31:0]            m_tx_data_o,
  output logic [1:0]             m_tx_vldb_o,
  output logic                   m_tx_valid_o,
  input  logic                   m_tx_ready_i,
  output logic                   m_tx_last_o,
  output logic                   m_tx_user_o,
  input  logic                   m_tx_status_i,
  input  logic                   m_tx_rsp_valid_i,
  output logic [NUM_SRC-1:0]     grant_o,
  output logic                   orphan_rsp_o
);

  localparam int IW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int DEPTH = 1 << ID_FIFO_AW;

  typedef enum logic {ST_IDLE, ST_XFER} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NUM_SRC-1:0]    r_grant;
  logic [NUM_SRC-1:0]    w_grant_nxt;
  logic [IW-1:0]         r_gidx;
  logic [IW-1:0]         w_gidx_nxt;
  logic [IW-1:0]         r_rr_ptr;
  logic [IW-1:0]         w_rr_ptr_nxt;
  logic [IW-1:0]         w_gidx_inc;

  logic [IW-1:0]         r_fifo [DEPTH];
  logic [ID_FIFO_AW-1:0] r_wp;
  logic [ID_FIFO_AW-1:0] r_rp;
  logic [ID_FIFO_AW:0]   r_cnt;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_orphan;

  logic [NUM_SRC-1:0]    r_rsp_valid;
  logic [NUM_SRC-1:0]    r_status;
  logic                  r_orphan;

  logic [NUM_SRC-1:0]    w_req;
  logic                  w_found;
  logic [IW-1:0]         w_pick;
  logic                  w_start;
  logic                  w_beat;
  logic                  w_last_beat;

  function automatic logic [IW-1:0] f_wrap(input logic [IW:0] v);
    if (v >= (IW+1)'(NUM_SRC)) begin
      return IW'(v - (IW+1)'(NUM_SRC));
    end
    return v[IW-1:0];
  endfunction

  assign w_full  = r_cnt[ID_FIFO_AW];
  assign w_empty = (r_cnt == '0);

  // first requester at or after rr_ptr, cyclic
  always_comb begin
    w_req = s_tx_valid_i;
`ifdef XM_TX_ARB_PRIO_EN
    w_req[0] = 1'b0;
`endif
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!w_found &&
          w_req[f_wrap({1'b0, r_rr_ptr} + (IW+1)'(i))]) begin
        w_found = 1'b1;
        w_pick  = f_wrap({1'b0, r_rr_ptr} + (IW+1)'(i));
      end
    end
`ifdef XM_TX_ARB_PRIO_EN
    if (s_tx_valid_i[0]) begin
      w_found = 1'b1;
      w_pick  = '0;
    end
`endif
  end

  assign w_start = (r_state == ST_IDLE) && link_up_i &&
                   !w_full && w_found;

  always_comb begin
    m_tx_data_o  = s_tx_data_i[32*r_gidx +: 32];
    m_tx_vldb_o  = s_tx_vldb_i[2*r_gidx +: 2];
    m_tx_last_o  = s_tx_last_i[r_gidx];
    m_tx_user_o  = s_tx_user_i[r_gidx];
    m_tx_valid_o = (r_state == ST_XFER) && s_tx_valid_i[r_gidx];
    s_tx_ready_o = '0;
    if (r_state == ST_XFER && m_tx_ready_i) begin
      s_tx_ready_o = r_grant;
    end
  end

  assign w_beat      = m_tx_valid_o && m_tx_ready_i;
  assign w_last_beat = w_beat && m_tx_last_o;
  assign w_gidx_inc  = f_wrap({1'b0, r_gidx} + (IW+1)'(1));

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_gidx_nxt   = r_gidx;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_XFER;
          w_grant_nxt = NUM_SRC'(1) << w_pick;
          w_gidx_nxt  = w_pick;
        end
      end
      ST_XFER: begin
        if (w_last_beat) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
`ifdef XM_TX_ARB_PRIO_EN
          if (r_gidx != '0) begin
            w_rr_ptr_nxt = w_gidx_inc;
          end
`else
          w_rr_ptr_nxt = w_gidx_inc;
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_user_clk_i or negedge tx_user_rst_n_i) begin
    if (!tx_user_rst_n_i) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_gidx   <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_gidx   <= w_gidx_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // a response arriving with the FIFO empty is never matched to a same-cycle push
  assign w_push   = w_last_beat;
  assign w_pop    = m_tx_rsp_valid_i && !w_empty;
  assign w_orphan = m_tx_rsp_valid_i && w_empty;

  always_ff @(posedge tx_user_clk_i or negedge tx_user_rst_n_i) begin
    if (!tx_user_rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wp] <= r_gidx;
        r_wp         <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge tx_user_clk_i or negedge tx_user_rst_n_i) begin
    if (!tx_user_rst_n_i) begin
      r_rsp_valid <= '0;
      r_status    <= '0;
      r_orphan    <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      r_status    <= '0;
      if (w_pop) begin
        r_rsp_valid[r_fifo[r_rp]] <= 1'b1;
        r_status[r_fifo[r_rp]]    <= m_tx_status_i;
      end
      if (w_orphan) begin
        r_orphan <= 1'b1;
      end
    end
  end

  assign s_tx_rsp_valid_o = r_rsp_valid;
  assign s_tx_status_o    = r_status;
  assign grant_o          = r_grant;
  assign orphan_rsp_o     = r_orphan;

endmodule

// File: tb/tb_xm_tx_frame_arb.sv
// tb_xm_tx_frame_arb: random frames from queued sources checked against a
// rule-level arbitration model and an in-order response routing model.
`timescale 1ns/1ps
module tb_xm_tx_frame_arb;
  localparam int NUM_SRC = 4;
  localparam int ID_FIFO_AW = 3;
`ifdef XM_TX_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  v;
    logic        l;
    logic        u;
  } beat_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  link_up;
  logic [NUM_SRC*32-1:0] s_tx_data_i = '0;
  logic [NUM_SRC*2-1:0]  s_tx_vldb_i = '0;
  logic [NUM_SRC-1:0]    s_tx_valid_i = '0;
  logic [NUM_SRC-1:0]    s_tx_ready_o;
  logic [NUM_SRC-1:0]    s_tx_last_i = '0;
  logic [NUM_SRC-1:0]    s_tx_user_i = '0;
  logic [NUM_SRC-1:0]    s_tx_status_o;
  logic [NUM_SRC-1:0]    s_tx_rsp_valid_o;
  logic [31:0]           m_tx_data_o;
  logic [1:0]            m_tx_vldb_o;
  logic                  m_tx_valid_o;
  logic                  m_tx_ready_i = 1'b1;
  logic                  m_tx_last_o;
  logic                  m_tx_user_o;
  logic                  m_tx_status_i;
  logic                  m_tx_rsp_valid_i;
  logic [NUM_SRC-1:0]    grant_o;
  logic                  orphan_rsp_o;

  always #5 clk = ~clk;

  xm_tx_frame_arb #(.NUM_SRC(NUM_SRC), .ID_FIFO_AW(ID_FIFO_AW)) dut (
    .tx_user_clk_i    (clk),
    .tx_user_rst_n_i  (rst_n),
    .link_up_i        (link_up),
    .s_tx_data_i      (s_tx_data_i),
    .s_tx_vldb_i      (s_tx_vldb_i),
    .s_tx_valid_i     (s_tx_valid_i),
    .s_tx_ready_o     (s_tx_ready_o),
    .s_tx_last_i      (s_tx_last_i),
    .s_tx_user_i      (s_tx_user_i),
    .s_tx_status_o    (s_tx_status_o),
    .s_tx_rsp_valid_o (s_tx_rsp_valid_o),
    .m_tx_data_o      (m_tx_data_o),
    .m_tx_vldb_o      (m_tx_vldb_o),
    .m_tx_valid_o     (m_tx_valid_o),
    .m_tx_ready_i     (m_tx_ready_i),
    .m_tx_last_o      (m_tx_last_o),
    .m_tx_user_o      (m_tx_user_o),
    .m_tx_status_i    (m_tx_status_i),
    .m_tx_rsp_valid_i (m_tx_rsp_valid_i),
    .grant_o          (grant_o),
    .orphan_rsp_o     (orphan_rsp_o)
  );

  int vectors = 0;
  int miscompares = 0;

  beat_t srcq [NUM_SRC][$];
  beat_t mq   [NUM_SRC][$];
  int    mlen [NUM_SRC][$];
  beat_t exp_b[$];
  int    exp_s[$];
  int    ids[$];
  beat_t obs_b[$];
  int    obs_c[$];
  logic [NUM_SRC-1:0] obs_g[$];
  int    cyc = 0;
  int    ready_bad = 0;
  int    rmode = 0;
  int    m_ptr = 0;
  logic [NUM_SRC-1:0] fire;
  logic [NUM_SRC-1:0] exp_rdy;

  // source BFMs + MAC-side monitor: sample at negedge, drive 1ns after posedge
  always begin
    @(negedge clk);
    cyc++;
    fire = s_tx_valid_i & s_tx_ready_o;
    exp_rdy = '0;
    if (m_tx_valid_o && m_tx_ready_i) begin
      obs_b.push_back({m_tx_data_o, m_tx_vldb_o, m_tx_last_o, m_tx_user_o});
      obs_c.push_back(cyc);
      obs_g.push_back(grant_o);
      exp_rdy = NUM_SRC'(1) << m_tx_data_o[31:28];
    end
    if (s_tx_ready_o !== exp_rdy) ready_bad++;
    @(posedge clk);
    #1;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (fire[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
      if (srcq[k].size() > 0) begin
        s_tx_data_i[32*k +: 32] = srcq[k][0].d;
        s_tx_vldb_i[2*k +: 2]   = srcq[k][0].v;
        s_tx_last_i[k]          = srcq[k][0].l;
        s_tx_user_i[k]          = srcq[k][0].u;
        s_tx_valid_i[k]         = 1'b1;
      end else begin
        s_tx_valid_i[k] = 1'b0;
      end
    end
    case (rmode)
      1:       m_tx_ready_i = 1'($urandom);
      2:       m_tx_ready_i = ~m_tx_ready_i;
      default: m_tx_ready_i = 1'b1;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic add_frame(input int s, input int len);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.d = {4'(s), 28'($urandom)};
      b.v = 2'($urandom);
      b.l = (j == len - 1);
      b.u = 1'($urandom);
      srcq[s].push_back(b);
      mq[s].push_back(b);
    end
    mlen[s].push_back(len);
  endtask

  // arbitration rules applied to the set of pending frames
  task automatic compute_expected();
    int pend [NUM_SRC];
    int g;
    int len;
    for (int k = 0; k < NUM_SRC; k++) pend[k] = mlen[k].size();
    while (1) begin
      g = -1;
      if (PRIO && pend[0] > 0) g = 0;
      else begin
        for (int i = 0; i < NUM_SRC; i++) begin
          int k;
          k = (m_ptr + i) % NUM_SRC;
          if (g < 0 && pend[k] > 0 && !(PRIO && k == 0)) g = k;
        end
      end
      if (g < 0) break;
      pend[g]--;
      len = mlen[g].pop_front();
      for (int j = 0; j < len; j++) begin
        exp_b.push_back(mq[g].pop_front());
        exp_s.push_back(g);
      end
      ids.push_back(g);
      if (!(PRIO && g == 0)) m_ptr = (g + 1) % NUM_SRC;
    end
  endtask

  task automatic wait_beats(input int n);
    int t;
    t = 0;
    while (obs_b.size() < n && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("beats_done", 64'(obs_b.size() >= n), 64'(1));
  endtask

  task automatic check_stream(input bit timing);
    beat_t o;
    for (int i = 0; i < exp_b.size(); i++) begin
      o = (i < obs_b.size()) ? obs_b[i] : '0;
      chk($sformatf("beat%0d", i), 64'(o), 64'(exp_b[i]));
      chk($sformatf("grant%0d", i),
          64'((i < obs_g.size()) ? obs_g[i] : '0),
          64'(NUM_SRC'(1) << exp_s[i]));
      if (timing && i > 0 && i < obs_c.size())
        chk($sformatf("gap%0d", i), 64'(obs_c[i] - obs_c[i-1]),
            64'(exp_b[i-1].l ? 2 : 1));
    end
    chk("beat_count", 64'(obs_b.size()), 64'(exp_b.size()));
    chk("ready_route", 64'(ready_bad), 64'(0));
    obs_b.delete();
    obs_c.delete();
    obs_g.delete();
    exp_b.delete();
    exp_s.delete();
    ready_bad = 0;
  endtask

  task automatic run_frames(input bit timing);
    compute_expected();
    wait_beats(exp_b.size());
    check_stream(timing);
  endtask

  task automatic respond(input logic st);
    int h;
    h = (ids.size() > 0) ? ids.pop_front() : -1;
    @(posedge clk);
    #1;
    m_tx_rsp_valid_i = 1'b1;
    m_tx_status_i    = st;
    @(posedge clk);
    #1;
    m_tx_rsp_valid_i = 1'b0;
    m_tx_status_i    = 1'b0;
    if (h >= 0) begin
      chk("rsp_valid", 64'(s_tx_rsp_valid_o), 64'(NUM_SRC'(1) << h));
      chk("rsp_status", 64'(s_tx_status_o), 64'(NUM_SRC'(st) << h));
    end else begin
      chk("orphan_no_pulse", 64'(s_tx_rsp_valid_o), 64'(0));
      chk("orphan_flag", 64'(orphan_rsp_o), 64'(1));
    end
  endtask

  task automatic respond_all();
    while (ids.size() > 0) respond(1'($urandom));
    @(posedge clk);
    #1;
    chk("rsp_idle", 64'(s_tx_rsp_valid_o), 64'(0));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    link_up = 1'b1;
    m_tx_rsp_valid_i = 1'b0;
    m_tx_status_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 64'(grant_o), 64'(0));
    chk("rst_mvalid", 64'(m_tx_valid_o), 64'(0));
    chk("rst_ready", 64'(s_tx_ready_o), 64'(0));
    chk("rst_rsp", 64'(s_tx_rsp_valid_o), 64'(0));
    chk("rst_status", 64'(s_tx_status_o), 64'(0));
    chk("rst_orphan", 64'(orphan_rsp_o), 64'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // round-robin, 3-beat frames, full-rate MAC
    rmode = 0;
    add_frame(0, 3);
    add_frame(0, 3);
    add_frame(1, 3);
    add_frame(2, 3);
    add_frame(3, 3);
    run_frames(1'b1);
    respond_all();

    // 5-beat frame under alternating backpressure
    rmode = 2;
    add_frame(2, 5);
    run_frames(1'b0);
    respond_all();

    // response routing 3,1,2 with status 1,0,1
    rmode = 0;
    add_frame(3, 2);
    run_frames(1'b1);
    add_frame(1, 4);
    run_frames(1'b1);
    add_frame(2, 1);
    run_frames(1'b1);
    respond(1'b1);
    respond(1'b0);
    respond(1'b1);

    // src0 keeps requesting
    add_frame(0, 2);
    add_frame(0, 2);
    add_frame(0, 2);
    add_frame(1, 2);
    run_frames(1'b1);
    respond_all();

    // randomized frame sets
    for (int r = 0; r < 6; r++) begin
      rmode = r % 3;
      for (int k = 0; k < NUM_SRC; k++) begin
        n = $urandom_range(0, 2);
        if (k == r % NUM_SRC && n == 0) n = 1;
        for (int f = 0; f < n; f++) add_frame(k, $urandom_range(1, 5));
      end
      run_frames(rmode == 0);
      respond_all();
    end

    // FIFO full blocks the 9th grant
    rmode = 0;
    add_frame(0, 2);
    add_frame(0, 2);
    add_frame(0, 2);
    for (int k = 1; k < NUM_SRC; k++) begin
      add_frame(k, 2);
      add_frame(k, 2);
    end
    compute_expected();
    wait_beats(16);
    repeat (10) @(posedge clk);
    #1;
    chk("full_grant", 64'(grant_o), 64'(0));
    chk("full_beats", 64'(obs_b.size()), 64'(16));
    chk("full_mvalid", 64'(m_tx_valid_o), 64'(0));
    respond(1'($urandom));
    wait_beats(18);
    check_stream(1'b0);
    respond_all();
    respond(1'b1);

    // link down: no grants; mid-frame drop lets the frame finish
    link_up = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) add_frame(k, 3);
    compute_expected();
    repeat (10) @(posedge clk);
    #1;
    chk("link_grant", 64'(grant_o), 64'(0));
    chk("link_beats", 64'(obs_b.size()), 64'(0));
    link_up = 1'b1;
    wait_beats(1);
    link_up = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("link_drop_beats", 64'(obs_b.size()), 64'(3));
    chk("link_drop_grant", 64'(grant_o), 64'(0));
    link_up = 1'b1;
    wait_beats(exp_b.size());
    check_stream(1'b0);
    respond_all();

    // reset in the middle of a frame
    add_frame(3, 6);
    compute_expected();
    wait_beats(2);
    @(negedge clk);
    #2;
    chk("pre_rst_orphan", 64'(orphan_rsp_o), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(s_tx_ready_o), 64'(0));
    chk("arst_mvalid", 64'(m_tx_valid_o), 64'(0));
    chk("arst_grant", 64'(grant_o), 64'(0));
    chk("arst_orphan", 64'(orphan_rsp_o), 64'(0));
    chk("arst_rsp", 64'(s_tx_rsp_valid_o), 64'(0));
    repeat (2) @(posedge clk);
    #2;
    for (int k = 0; k < NUM_SRC; k++) begin
      srcq[k].delete();
      mq[k].delete();
      mlen[k].delete();
    end
    exp_b.delete();
    exp_s.delete();
    obs_b.delete();
    obs_c.delete();
    obs_g.delete();
    ids.delete();
    m_ptr = 0;
    add_frame(3, 2);
    add_frame(1, 2);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_frames(1'b0);
    respond_all();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
